// File: rtl/hcsr04_controller.sv
// HC-SR04 ultrasonic ranging sequencer.
// Issues the trigger pulse, times the synchronised echo and converts the
// echo width to whole centimetres. Runs single-shot on start or back-to-back
// while continuous is held high, with a quiet holdoff after every measurement.
`timescale 1ns/1ps

module hcsr04_controller #(
    parameter int TRIG_CYCLES      = 500,
    parameter int CYCLES_PER_CM    = 2900,
    parameter int ECHO_WAIT_CYCLES = 1500000,
    parameter int ECHO_MAX_CYCLES  = 1250000,
    parameter int HOLDOFF_CYCLES   = 3000000,
    parameter int DIST_W           = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic              echo,
    output logic              trigger,
    output logic              busy,
    output logic [DIST_W-1:0] distance_cm,
    output logic              valid,
    output logic              timeout
);

    localparam int TRIG_W = $clog2(TRIG_CYCLES) + 1;
    localparam int PRE_W  = $clog2(CYCLES_PER_CM) + 1;
    localparam int WAIT_W = $clog2(ECHO_WAIT_CYCLES) + 1;
    localparam int MAX_W  = $clog2(ECHO_MAX_CYCLES) + 1;
    localparam int HOLD_W = $clog2(HOLDOFF_CYCLES) + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TRIG    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_MEASURE = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CYCLES_PER_CM - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ECHO_WAIT_CYCLES - 1);
    localparam logic [MAX_W-1:0]  MAX_LAST  = MAX_W'(ECHO_MAX_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

    // Centimetre counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
        return (&v) ? v : v + DIST_W'(1);
    endfunction

    logic [2:0]        state;
    logic              echo_meta;
    logic              echo_s;
    logic              echo_d;
    logic              rise;
    logic              fall;
    logic [TRIG_W-1:0] trig_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [PRE_W-1:0]  presc;
    logic [DIST_W-1:0] cm_cnt;
    logic [MAX_W-1:0]  echo_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              presc_wrap;
    logic [DIST_W-1:0] cm_next;

    assign rise = echo_s & ~echo_d;
    assign fall = ~echo_s & echo_d;

    // The cycle that sees the fall still counts as an echo-high cycle, so the
    // captured distance uses the post-increment value of the cm counter.
    assign presc_wrap = (presc == PRE_LAST);
    assign cm_next    = presc_wrap ? sat_inc(cm_cnt) : cm_cnt;

    // Two-flop synchroniser for the asynchronous echo pin plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_d    <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
            echo_d    <= echo_s;
        end
    end

    // Measurement sequencer: trigger, echo wait, echo timing, holdoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            trigger     <= 1'b0;
            busy        <= 1'b0;
            distance_cm <= '0;
            valid       <= 1'b0;
            timeout     <= 1'b0;
            trig_cnt    <= '0;
            wait_cnt    <= '0;
            presc       <= '0;
            cm_cnt      <= '0;
            echo_cnt    <= '0;
            hold_cnt    <= '0;
        end else begin
            valid   <= 1'b0;
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start || continuous) begin
                        state    <= S_TRIG;
                        trigger  <= 1'b1;
                        busy     <= 1'b1;
                        trig_cnt <= '0;
                    end
                end
                S_TRIG: begin
                    if (trig_cnt == TRIG_LAST) begin
                        trigger  <= 1'b0;
                        state    <= S_WAIT;
                        wait_cnt <= '0;
                    end else begin
                        trig_cnt <= trig_cnt + TRIG_W'(1);
                    end
                end
                S_WAIT: begin
                    if (rise) begin
                        state    <= S_MEASURE;
                        presc    <= '0;
                        cm_cnt   <= '0;
                        echo_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout     <= 1'b1;
                        distance_cm <= '1;
                        state       <= S_HOLDOFF;
                        hold_cnt    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_MEASURE: begin
                    presc    <= presc_wrap ? '0 : presc + PRE_W'(1);
                    cm_cnt   <= cm_next;
                    echo_cnt <= echo_cnt + MAX_W'(1);
                    if (fall) begin
                        distance_cm <= cm_next;
                        valid       <= 1'b1;
                        state       <= S_HOLDOFF;
                        hold_cnt    <= '0;
                    end else if (echo_cnt == MAX_LAST) begin
                        timeout     <= 1'b1;
                        distance_cm <= '1;
                        state       <= S_HOLDOFF;
                        hold_cnt    <= '0;
                    end
                end
                S_HOLDOFF: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (continuous) begin
                            state    <= S_TRIG;
                            trigger  <= 1'b1;
                            trig_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    trigger <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hcsr04_controller.sv
// Scoreboard bench for hcsr04_controller with small timing parameters.
`timescale 1ns/1ps

module tb_hcsr04_controller;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          echo = 1'b0;
    logic          trigger;
    logic          busy;
    logic [DW-1:0] distance_cm;
    logic          valid;
    logic          timeout;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic          is_to;
        logic [DW-1:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    hcsr04_controller #(
        .TRIG_CYCLES      (4),
        .CYCLES_PER_CM    (10),
        .ECHO_WAIT_CYCLES (50),
        .ECHO_MAX_CYCLES  (400),
        .HOLDOFF_CYCLES   (20),
        .DIST_W           (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .continuous  (continuous),
        .echo        (echo),
        .trigger     (trigger),
        .busy        (busy),
        .distance_cm (distance_cm),
        .valid       (valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid/timeout pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (valid === 1'b1 || timeout === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_event: valid=%0b timeout=%0b distance=%0d, want no event",
                         valid, timeout, distance_cm);
            end else begin
                mon_e = sb.pop_front();
                if (valid === ~mon_e.is_to && timeout === mon_e.is_to && distance_cm === mon_e.d)
                    n_pass++;
                else
                    $display("FAIL result: valid=%0b timeout=%0b distance=%0d, want valid=%0b timeout=%0b distance=%0d",
                             valid, timeout, distance_cm, ~mon_e.is_to, mon_e.is_to, mon_e.d);
            end
        end
    end

    // One measurement with the sensor model: echo rises 5 cycles after trigger
    // falls and stays high len cycles (len=0: silent sensor).
    // post: 0 = expect busy low 20 cycles after the result, 1 = expect a new
    // trigger 20 cycles after the result, 2 = no follow-up timing check.
    task automatic measure(input int len, input bit exp_to, input logic [DW-1:0] exp_d,
                           input int post, input bit drop_cont, input bit poke_start);
        int   k;
        int   hi;
        int   to_at;
        exp_t e;
        e.is_to = exp_to;
        e.d     = exp_d;
        sb.push_back(e);

        k = 0;
        while (trigger !== 1'b1 && k < 100) begin tick; k++; end
        if (trigger !== 1'b1) begin
            check("trigger_start", trigger, 1);
            return;
        end
        hi = 0;
        while (trigger === 1'b1 && hi < 100) begin hi++; tick; end
        check("trigger_width", hi, 4);

        if (len == 0) begin
            k = 0;
            while (timeout !== 1'b1 && k < 200) begin tick; k++; end
            check("timeout_delay", k, 50);
        end else begin
            repeat (5) tick;
            echo  = 1'b1;
            to_at = -1;
            for (int i = 0; i < len; i++) begin
                tick;
                if (timeout === 1'b1 && to_at < 0) to_at = i + 1;
                if (poke_start && i == 10) start = 1'b1;
                if (i == 11) start = 1'b0;
                if (drop_cont && i == 20) continuous = 1'b0;
            end
            echo = 1'b0;
            if (exp_to) begin
                // 400 counted echo cycles plus 3 cycles of synchroniser and edge detect.
                check("echo_timeout_at", to_at, 403);
            end else begin
                k = 0;
                while (valid !== 1'b1 && k < 20) begin tick; k++; end
                check("valid_seen", valid, 1);
            end
        end

        if (post == 0) begin
            k = 0;
            while (busy === 1'b1 && k < 100) begin tick; k++; end
            check("busy_low_delay", k, 20);
        end else if (post == 1) begin
            k = 0;
            while (trigger !== 1'b1 && k < 100) begin tick; k++; end
            check("retrigger_delay", k, 20);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        int   k;
        logic act;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_trigger", trigger, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_distance", distance_cm, 0);
        rst_n = 1'b1;
        tick; tick;

        // Single shot, 123 echo cycles -> 12 cm
        start = 1'b1; tick; start = 1'b0;
        measure(123, 1'b0, 8'd12, 0, 1'b0, 1'b0);

        // Boundary widths
        start = 1'b1; tick; start = 1'b0;
        measure(9, 1'b0, 8'd0, 0, 1'b0, 1'b0);
        start = 1'b1; tick; start = 1'b0;
        measure(10, 1'b0, 8'd1, 0, 1'b0, 1'b0);

        // Silent sensor
        start = 1'b1; tick; start = 1'b0;
        measure(0, 1'b1, 8'd255, 0, 1'b0, 1'b0);

        // Overlong echo; its late fall must not produce a result
        start = 1'b1; tick; start = 1'b0;
        measure(500, 1'b1, 8'd255, 2, 1'b0, 1'b0);
        repeat (30) tick;
        check("busy_after_overlong", busy, 0);

        // Continuous mode with start pokes while busy; continuous dropped in the third
        continuous = 1'b1;
        measure(57, 1'b0, 8'd5, 1, 1'b0, 1'b1);
        measure(230, 1'b0, 8'd23, 1, 1'b0, 1'b1);
        measure(57, 1'b0, 8'd5, 0, 1'b1, 1'b1);
        act = 1'b0;
        repeat (60) begin tick; if (trigger !== 1'b0 || busy !== 1'b0) act = 1'b1; end
        check("idle_after_continuous", act, 0);

        // Reset during MEASURE
        start = 1'b1; tick; start = 1'b0;
        k = 0;
        while (trigger === 1'b1 && k < 20) begin tick; k++; end
        repeat (5) tick;
        echo = 1'b1;
        repeat (30) tick;
        check("busy_in_measure", busy, 1);
        check("distance_before_reset", distance_cm, 5);
        #2 rst_n = 1'b0;
        #1;
        check("rstm_trigger", trigger, 0);
        check("rstm_busy", busy, 0);
        check("rstm_valid", valid, 0);
        check("rstm_distance", distance_cm, 0);
        echo = 1'b0;
        tick;
        rst_n = 1'b1;
        act = 1'b0;
        repeat (80) begin tick; if (trigger !== 1'b0 || busy !== 1'b0) act = 1'b1; end
        check("idle_after_reset", act, 0);

        // Reset while the trigger is high: it must drop without a clock edge
        start = 1'b1; tick; start = 1'b0;
        check("trigger_before_reset", trigger, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstt_trigger", trigger, 0);
        check("rstt_busy", busy, 0);
        tick;
        rst_n = 1'b1;
        act = 1'b0;
        repeat (20) begin tick; if (trigger !== 1'b0 || busy !== 1'b0) act = 1'b1; end
        check("idle_after_trig_reset", act, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
